// File: rtl/ajcrisc_pkg.sv
// ajcRISC shared definitions: datapath width, opcodes, machine-cycle,
// write-back select and source select encodings used across the control
// unit and its front-end blocks.
package ajcrisc_pkg;

  // Single shared width for data, instructions and addresses.
  localparam int DATA_W = 8;

  // Upper nibble of the instruction word.
  typedef enum logic [3:0] {
    OP_ADD = 4'h0,
    OP_SUB = 4'h1,
    OP_AND = 4'h2,
    OP_OR  = 4'h3,
    OP_XOR = 4'h4,
    OP_NOT = 4'h5,
    OP_SHL = 4'h6,
    OP_SHR = 4'h7,
    OP_LDI = 4'h8,
    OP_LD  = 4'h9,
    OP_ST  = 4'hA,
    OP_JMP = 4'hB,
    OP_JZ  = 4'hC,
    OP_JC  = 4'hD,
    OP_IN  = 4'hE,
    OP_OUT = 4'hF
  } opcode_e;

  // Machine cycles: MC0 fetch, MC1 decode, MC2 operand/base+index capture,
  // MC3 effective address compute, MC4 data access / jump.
  typedef enum logic [2:0] {
    MC0 = 3'd0,
    MC1 = 3'd1,
    MC2 = 3'd2,
    MC3 = 3'd3,
    MC4 = 3'd4
  } mc_e;

  // Register-file write-back source.
  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_IN  = 2'd2,
    WB_IMM = 2'd3
  } wb_sel_e;

  // ALU second operand source.
  typedef enum logic [0:0] {
    SRC_REG = 1'b0,
    SRC_IMM = 1'b1
  } src_sel_e;

endpackage

// File: rtl/ajcrisc_pc_counter.sv
// Program counter register with clear > load > increment priority.
// Ports: clk, rst_n (async active-low), rst_pc/ld_pc/cnt_pc strobes,
//        load_val (jump target), pc (current program counter).
module ajcrisc_pc_counter #(
  parameter int DATA_W = ajcrisc_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rst_pc,
  input  logic              ld_pc,
  input  logic              cnt_pc,
  input  logic [DATA_W-1:0] load_val,
  output logic [DATA_W-1:0] pc
);

  localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

  logic [DATA_W-1:0] pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= '0;
    end else if (rst_pc) begin
      pc_q <= '0;
    end else if (ld_pc) begin
      pc_q <= load_val;
    end else if (cnt_pc) begin
      // Natural wrap: all-ones rolls over to zero.
      pc_q <= pc_q + ONE;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/ajcrisc_fetch_addr_unit.sv
// ajcRISC fetch/address front end: PC, IR, MABR, MAXR, MAR and the
// single memory address bus mux (MAR during the data phase, else PC).
// Ports: Clock, Reset_n (async active-low); control strobes RST_PC, LD_PC,
//        CNT_PC, LD_IR, LD_MABR, LD_MAXR, LD_MAR; MEM_RDATA, SRC1_DATA in;
//        MEM_ADDR, IW, PC_OUT, DATA_PHASE out. All outputs come from registers.
module ajcrisc_fetch_addr_unit #(
  parameter int DATA_W = ajcrisc_pkg::DATA_W
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              RST_PC,
  input  logic              LD_PC,
  input  logic              CNT_PC,
  input  logic              LD_IR,
  input  logic              LD_MABR,
  input  logic              LD_MAXR,
  input  logic              LD_MAR,
  input  logic [DATA_W-1:0] MEM_RDATA,
  input  logic [DATA_W-1:0] SRC1_DATA,
  output logic [DATA_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] IW,
  output logic [DATA_W-1:0] PC_OUT,
  output logic              DATA_PHASE
);

  logic [DATA_W-1:0] pc;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] mabr;
  logic [DATA_W-1:0] maxr;
  logic [DATA_W-1:0] mar;
  logic              data_phase;

  ajcrisc_pc_counter #(
    .DATA_W (DATA_W)
  ) u_pc (
    .clk      (Clock),
    .rst_n    (Reset_n),
    .rst_pc   (RST_PC),
    .ld_pc    (LD_PC),
    .cnt_pc   (CNT_PC),
    .load_val (mar),
    .pc       (pc)
  );

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      ir         <= '0;
      mabr       <= '0;
      maxr       <= '0;
      mar        <= '0;
      data_phase <= 1'b0;
    end else begin
      if (LD_IR) begin
        ir <= MEM_RDATA;
      end
      if (LD_MABR) begin
        mabr <= MEM_RDATA;
      end
      if (LD_MAXR) begin
        maxr <= SRC1_DATA;
      end
      // Sum uses the pre-edge MABR/MAXR; carry out is dropped.
      if (LD_MAR) begin
        mar <= mabr + maxr;
      end
      // One cycle per LD_MAR pulse; consecutive pulses keep it high.
      data_phase <= LD_MAR;
    end
  end

  // Mux of registered values only, so the bus cannot glitch from inputs.
  assign MEM_ADDR   = data_phase ? mar : pc;
  assign IW         = ir;
  assign PC_OUT     = pc;
  assign DATA_PHASE = data_phase;

endmodule

// File: tb/tb_ajcrisc_fetch_addr_unit.sv
// Directed bench for ajcrisc_fetch_addr_unit: a table of per-edge strobe
// vectors with hand-computed outputs, plus a mid-run reset sequence.
module tb_ajcrisc_fetch_addr_unit;

  localparam int W = 8;

  localparam logic [6:0] S_NONE = 7'b0000000;
  localparam logic [6:0] S_RST  = 7'b1000000;
  localparam logic [6:0] S_LDPC = 7'b0100000;
  localparam logic [6:0] S_CNT  = 7'b0010000;
  localparam logic [6:0] S_IR   = 7'b0001000;
  localparam logic [6:0] S_MABR = 7'b0000100;
  localparam logic [6:0] S_MAXR = 7'b0000010;
  localparam logic [6:0] S_MAR  = 7'b0000001;

  typedef struct {
    logic [6:0]   strb;
    logic [W-1:0] rdata;
    logic [W-1:0] src1;
    logic [W-1:0] e_addr;
    logic [W-1:0] e_iw;
    logic [W-1:0] e_pc;
    logic         e_dp;
  } vec_t;

  logic         Clock = 1'b0;
  logic         Reset_n;
  logic         RST_PC, LD_PC, CNT_PC, LD_IR, LD_MABR, LD_MAXR, LD_MAR;
  logic [W-1:0] MEM_RDATA, SRC1_DATA;
  logic [W-1:0] MEM_ADDR, IW, PC_OUT;
  logic         DATA_PHASE;

  int errors = 0;
  int checks = 0;

  vec_t vec [24];

  ajcrisc_fetch_addr_unit #(
    .DATA_W (W)
  ) dut (
    .Clock      (Clock),
    .Reset_n    (Reset_n),
    .RST_PC     (RST_PC),
    .LD_PC      (LD_PC),
    .CNT_PC     (CNT_PC),
    .LD_IR      (LD_IR),
    .LD_MABR    (LD_MABR),
    .LD_MAXR    (LD_MAXR),
    .LD_MAR     (LD_MAR),
    .MEM_RDATA  (MEM_RDATA),
    .SRC1_DATA  (SRC1_DATA),
    .MEM_ADDR   (MEM_ADDR),
    .IW         (IW),
    .PC_OUT     (PC_OUT),
    .DATA_PHASE (DATA_PHASE)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [6:0] s, input logic [W-1:0] rd, input logic [W-1:0] s1);
    {RST_PC, LD_PC, CNT_PC, LD_IR, LD_MABR, LD_MAXR, LD_MAR} = s;
    MEM_RDATA = rd;
    SRC1_DATA = s1;
  endtask

  // Drive on the falling edge, let one rising edge pass, sample 1 time unit later.
  task automatic step(input logic [6:0] s, input logic [W-1:0] rd, input logic [W-1:0] s1);
    @(negedge Clock);
    drive(s, rd, s1);
    @(posedge Clock);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [W-1:0] addr, input logic [W-1:0] iw,
                           input logic [W-1:0] pc, input logic dp);
    check({tag, ".MEM_ADDR"}, MEM_ADDR, addr);
    check({tag, ".IW"}, IW, iw);
    check({tag, ".PC_OUT"}, PC_OUT, pc);
    check({tag, ".DATA_PHASE"}, {7'd0, DATA_PHASE}, {7'd0, dp});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            strobes                       rdata  src1   addr   iw     pc     dp
    vec[0]  = '{S_CNT,                          8'h00, 8'h00, 8'h01, 8'h00, 8'h01, 1'b0};
    vec[1]  = '{S_CNT,                          8'h00, 8'h00, 8'h02, 8'h00, 8'h02, 1'b0};
    vec[2]  = '{S_CNT,                          8'h00, 8'h00, 8'h03, 8'h00, 8'h03, 1'b0};
    vec[3]  = '{S_MABR | S_MAXR,                8'h10, 8'h00, 8'h03, 8'h00, 8'h03, 1'b0};
    vec[4]  = '{S_MAR,                          8'h00, 8'h00, 8'h10, 8'h00, 8'h03, 1'b1};
    vec[5]  = '{S_LDPC,                         8'h00, 8'h00, 8'h10, 8'h00, 8'h10, 1'b0};
    // Fetch at PC=0x10.
    vec[6]  = '{S_IR | S_CNT,                   8'hD1, 8'h00, 8'h11, 8'hD1, 8'h11, 1'b0};
    // MC2 capture, MC3 address, MC4 data phase with wrapped sum 0xF0+0x25.
    vec[7]  = '{S_MABR | S_MAXR | S_CNT,        8'hF0, 8'h25, 8'h12, 8'hD1, 8'h12, 1'b0};
    vec[8]  = '{S_MAR,                          8'h00, 8'h00, 8'h15, 8'hD1, 8'h12, 1'b1};
    vec[9]  = '{S_NONE,                         8'hAA, 8'hBB, 8'h12, 8'hD1, 8'h12, 1'b0};
    // Simultaneous load + LD_MAR: sum uses old F0+25; then back-to-back LD_MAR sees 30+12.
    vec[10] = '{S_MABR | S_MAXR | S_MAR,        8'h30, 8'h12, 8'h15, 8'hD1, 8'h12, 1'b1};
    vec[11] = '{S_MAR,                          8'h00, 8'h00, 8'h42, 8'hD1, 8'h12, 1'b1};
    // Jump during data phase.
    vec[12] = '{S_LDPC,                         8'h00, 8'h00, 8'h42, 8'hD1, 8'h42, 1'b0};
    vec[13] = '{S_MABR | S_MAXR,                8'h7F, 8'h01, 8'h42, 8'hD1, 8'h42, 1'b0};
    vec[14] = '{S_MAR,                          8'h00, 8'h00, 8'h80, 8'hD1, 8'h42, 1'b1};
    // Priority: clear beats load and count; load beats count.
    vec[15] = '{S_RST | S_LDPC | S_CNT,         8'h00, 8'h00, 8'h00, 8'hD1, 8'h00, 1'b0};
    vec[16] = '{S_LDPC | S_CNT,                 8'h00, 8'h00, 8'h80, 8'hD1, 8'h80, 1'b0};
    vec[17] = '{S_MABR | S_MAXR,                8'hFE, 8'h01, 8'h80, 8'hD1, 8'h80, 1'b0};
    vec[18] = '{S_MAR,                          8'h00, 8'h00, 8'hFF, 8'hD1, 8'h80, 1'b1};
    vec[19] = '{S_LDPC,                         8'h00, 8'h00, 8'hFF, 8'hD1, 8'hFF, 1'b0};
    // Wrap 0xFF -> 0x00.
    vec[20] = '{S_CNT,                          8'h00, 8'h00, 8'h00, 8'hD1, 8'h00, 1'b0};
    vec[21] = '{S_IR,                           8'hB4, 8'h00, 8'h00, 8'hB4, 8'h00, 1'b0};
    vec[22] = '{S_CNT,                          8'h00, 8'h00, 8'h01, 8'hB4, 8'h01, 1'b0};
    vec[23] = '{S_RST | S_CNT,                  8'h00, 8'h00, 8'h00, 8'hB4, 8'h00, 1'b0};

    Reset_n = 1'b0;
    drive(S_NONE, 8'h00, 8'h00);
    #2;
    check_all("reset", 8'h00, 8'h00, 8'h00, 1'b0);

    @(negedge Clock);
    Reset_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      step(vec[i].strb, vec[i].rdata, vec[i].src1);
      check_all($sformatf("vec%0d", i), vec[i].e_addr, vec[i].e_iw, vec[i].e_pc, vec[i].e_dp);
    end

    // IW must not follow MEM_RDATA combinationally.
    @(negedge Clock);
    drive(S_NONE, 8'h99, 8'h00);
    #1;
    check("iw_no_comb_path", IW, 8'hB4);

    // Reach PC=0x37, IR=0xB4 with a data phase in progress, then reset mid-cycle.
    step(S_MABR | S_MAXR, 8'h37, 8'h00);
    step(S_MAR, 8'h00, 8'h00);
    check("pre_rst.MEM_ADDR", MEM_ADDR, 8'h37);
    step(S_LDPC, 8'h00, 8'h00);
    check("pre_rst.PC_OUT", PC_OUT, 8'h37);
    check("pre_rst.IW", IW, 8'hB4);
    step(S_MAR, 8'h00, 8'h00);
    check("pre_rst.DATA_PHASE", {7'd0, DATA_PHASE}, 8'h01);

    #2;
    drive(S_CNT | S_IR | S_MAR, 8'h55, 8'h66);
    Reset_n = 1'b0;
    #1;
    check_all("async_rst", 8'h00, 8'h00, 8'h00, 1'b0);

    // Strobes held through reset edges have no effect.
    @(posedge Clock);
    @(posedge Clock);
    #1;
    check_all("rst_hold", 8'h00, 8'h00, 8'h00, 1'b0);

    @(negedge Clock);
    Reset_n = 1'b1;
    drive(S_CNT, 8'h55, 8'h00);
    for (int k = 0; k < 3; k++) begin
      @(posedge Clock);
      #1;
      check($sformatf("rel%0d.DATA_PHASE", k), {7'd0, DATA_PHASE}, 8'h00);
    end
    check_all("post_rst", 8'h03, 8'h00, 8'h03, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
